shiftreg_serdes: RTL

- Parametrised serialiser/deserialiser built around a single WIDTH-bit shift register; successor to the plain serial-in shift register.
- Runtime mode selects the direction:
  - SIPO: collects WIDTH serial bits and presents one parallel word.
  - PISO: accepts one parallel word and emits it bit by bit.
- Both sides use valid/ready handshakes. Sits between bit-serial links (SPI-style, test scan paths) and word-wide datapaths.

---
 rtl/shiftreg_pkg.sv | 14 +
 rtl/shiftreg_core.sv | 45 ++++
 rtl/shiftreg_serdes.sv | 115 +++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared state and mode encodings for the shift-register serdes
package shiftreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_OUT  = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    localparam logic MODE_SIPO = 1'b0;
    localparam logic MODE_PISO = 1'b1;

endpackage

// File: rtl/shiftreg_core.sv
// rtl/shiftreg_core.sv - WIDTH-bit register with parallel load and directional shift
module shiftreg_core #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // One shift serves both directions: serial-in enters at the far end while the
    // serial-out bit leaves from the near end.
    always_comb begin
        data_d = data_q;
        if (i_load) begin
            data_d = i_load_data;
        end else if (i_shift) begin
            if (MSB_FIRST != 0) begin
                data_d = {data_q[WIDTH-2:0], i_ser_in};
            end else begin
                data_d = {i_ser_in, data_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data    = data_q;
    assign o_ser_out = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/shiftreg_serdes.sv
// rtl/shiftreg_serdes.sv - runtime-selectable SIPO/PISO serdes with valid/ready handshakes
module shiftreg_serdes
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_mode,
    input  logic                       i_ser_valid,
    input  logic                       i_ser_data,
    output logic                       o_ser_valid,
    output logic                       o_ser_data,
    input  logic                       i_ser_ready,
    input  logic                       i_par_valid,
    input  logic [WIDTH-1:0]           i_par_data,
    output logic                       o_par_ready,
    output logic                       o_par_valid,
    output logic [WIDTH-1:0]           o_par_data,
    input  logic                       i_par_ready,
    output logic [$clog2(WIDTH+1)-1:0] o_count,
    output logic                       o_drop
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           load;
    logic           shift;
    logic           ser_in;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        shift   = 1'b0;
        ser_in  = i_ser_data;
        case (state_q)
            ST_IDLE: begin
                if (i_mode == MODE_SIPO && i_ser_valid) begin
                    shift   = 1'b1;
                    count_d = CW'(1);
                    state_d = ST_RX;
                end else if (i_mode == MODE_PISO && i_par_valid) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_TX;
                end
            end
            ST_RX: begin
                if (i_ser_valid) begin
                    shift   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (i_par_ready) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_TX: begin
                // Zero-fill the vacated end so a finished word leaves a clean register.
                ser_in = 1'b0;
                if (i_ser_ready) begin
                    shift   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    shiftreg_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_load_data (i_par_data),
        .i_shift     (shift),
        .i_ser_in    (ser_in),
        .o_data      (o_par_data),
        .o_ser_out   (o_ser_data)
    );

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_par_ready = !i_rst && (state_q == ST_IDLE) && (i_mode == MODE_PISO);
    assign o_par_valid = (state_q == ST_OUT);
    assign o_ser_valid = (state_q == ST_TX);
    assign o_drop      = (state_q == ST_OUT) && i_ser_valid;
    assign o_count     = count_q;

endmodule
